// File: rtl/spi_shift_engine_pkg.sv
// Shared FSM state type and frame-size constant for the SPI shift engine.
// Latency: none (types and constants only).
// Backpressure: none.
package SPI_package;

  // Largest frame the engine can shift, in bits.
  localparam int SPI_MAX_LEN = 32;

  // Frame sequencing: select asserted (LEAD), clocking (SHIFT), hold after last edge (TRAIL).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    SHIFT = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine_baud_gen.sv
// Half-period tick generator for the SPI shift engine.
// Latency: first tick spi_br+1 cycles after enable rises, then every spi_br+1 cycles.
// Backpressure: none; free-running while enable is high, held at zero otherwise.
// Ports: clk/rst (sync, active-high), enable, spi_br (divisor), half_tick (1-cycle pulse).
module spi_baud_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] spi_br,
  output logic       half_tick
);

  logic [7:0] r_cnt;
  logic       w_wrap;

  // Count runs 0..spi_br, so spi_br=255 still fits in 8 bits.
  assign w_wrap    = (r_cnt == spi_br);
  assign half_tick = enable & w_wrap;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: sends/receives one frame of 1..SPI_MAX_LEN bits per accepted request.
// Latency: ack 1 cycle after request; frame lasts (2*(data_len+1)+2)*(spi_br+1) cycles after ack.
// Backpressure: requests are ignored while a frame is active; a held request yields one frame.
// Ports: clk/rst; transfer_start/_ack/_complete handshake; mstr,cpol,cpha,dord,talk mode;
//        data_len, spi_br, tx_data latched at accept; rx_data result; sck/mosi/ss_n/miso pins.
module spi_shift_engine #(
  parameter int SPI_MAX_LEN = SPI_package::SPI_MAX_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           transfer_start,
  output logic                           transfer_start_ack,
  output logic                           transfer_complete,
  input  logic                           mstr,
  input  logic                           cpol,
  input  logic                           cpha,
  input  logic                           dord,
  input  logic                           talk,
  input  logic [$clog2(SPI_MAX_LEN)-1:0] data_len,
  input  logic [7:0]                     spi_br,
  input  logic [SPI_MAX_LEN-1:0]         tx_data,
  output logic [SPI_MAX_LEN-1:0]         rx_data,
  output logic                           sck,
  output logic                           mosi,
  input  logic                           miso,
  output logic                           ss_n
);

  import SPI_package::spi_state_e;
  import SPI_package::IDLE;
  import SPI_package::LEAD;
  import SPI_package::SHIFT;
  import SPI_package::TRAIL;

  localparam int LW = $clog2(SPI_MAX_LEN);

  spi_state_e             r_state, w_next_state;
  logic [SPI_MAX_LEN-1:0] r_tx, r_rx_shift, r_rx_data;
  logic [LW-1:0]          r_len;
  logic [7:0]             r_br;
  logic [LW:0]            r_edge;          // SCK edges already produced in this frame
  logic                   r_cpha, r_dord, r_talk;
  logic                   r_sck, r_mosi, r_ss_n, r_ack, r_complete, r_armed;

  logic                   w_baud_en, w_tick, w_accept, w_leading, w_last_edge, w_sample;
  logic                   w_tx_bit, w_first_bit;
  logic [LW-1:0]          w_bit_k, w_tx_idx, w_rx_idx;

  spi_baud_gen u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .enable    (w_baud_en),
    .spi_br    (r_br),
    .half_tick (w_tick)
  );

  assign w_baud_en   = (r_state != IDLE);
  assign w_accept    = (r_state == IDLE) && transfer_start && mstr && r_armed;
  // The upcoming edge is odd-numbered (leading) when an even count has been produced.
  assign w_leading   = ~r_edge[0];
  assign w_last_edge = (r_edge == {r_len, 1'b1});
  // Edges 2k+1 and 2k+2 both belong to bit k.
  assign w_bit_k     = r_edge[LW:1];
  // cpha=0 samples on leading edges, cpha=1 on trailing edges.
  assign w_sample    = w_leading ^ r_cpha;
  // cpha=1 drives bit k on its leading edge; cpha=0 drives bit k+1 on the trailing edge of bit k.
  assign w_tx_idx    = r_cpha ? w_bit_k : w_bit_k + LW'(1);
  assign w_tx_bit    = r_dord ? r_tx[w_tx_idx] : r_tx[r_len - w_tx_idx];
  assign w_rx_idx    = r_dord ? w_bit_k : r_len - w_bit_k;
  assign w_first_bit = dord ? tx_data[0] : tx_data[data_len];

  assign transfer_start_ack = r_ack;
  assign transfer_complete  = r_complete;
  assign rx_data            = r_rx_data;
  assign sck                = r_sck;
  assign mosi               = r_mosi;
  assign ss_n               = r_ss_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)              w_next_state = LEAD;
      LEAD:    if (w_tick)                w_next_state = SHIFT;
      SHIFT:   if (w_tick && w_last_edge) w_next_state = TRAIL;
      TRAIL:   if (w_tick)                w_next_state = IDLE;
      default:                            w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx       <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_len      <= '0;
      r_br       <= '0;
      r_edge     <= '0;
      r_cpha     <= 1'b0;
      r_dord     <= 1'b0;
      r_talk     <= 1'b0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b1;
      r_ss_n     <= 1'b1;
      r_ack      <= 1'b0;
      r_complete <= 1'b0;
      r_armed    <= 1'b1;
    end else begin
      r_ack <= w_accept;
      // Re-arm only once the request has been seen low.
      if (!transfer_start) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_sck  <= cpol;
          r_mosi <= 1'b1;
          if (w_accept) begin
            r_armed    <= 1'b0;
            r_complete <= 1'b0;
            r_ss_n     <= 1'b0;
            r_tx       <= tx_data;
            r_len      <= data_len;
            r_br       <= spi_br;
            r_cpha     <= cpha;
            r_dord     <= dord;
            r_talk     <= talk;
            r_edge     <= '0;
            r_rx_shift <= '0;
            // cpha=0 needs the first bit valid before edge 1.
            r_mosi     <= (!cpha && talk) ? w_first_bit : 1'b1;
          end
        end
        SHIFT: begin
          if (w_tick) begin
            r_sck  <= ~r_sck;
            r_edge <= w_last_edge ? '0 : r_edge + (LW+1)'(1);
            if (w_sample) begin
              r_rx_shift[w_rx_idx] <= miso;
            end
            if (r_talk) begin
              if (r_cpha && w_leading) begin
                r_mosi <= w_tx_bit;
              end else if (!r_cpha && !w_leading && !w_last_edge) begin
                r_mosi <= w_tx_bit;
              end
            end
          end
        end
        TRAIL: begin
          if (w_tick) begin
            r_ss_n     <= 1'b1;
            r_complete <= 1'b1;
            r_rx_data  <= r_rx_shift;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: table vectors, corner sequences, random frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_shift_engine;

  logic        clk = 1'b0;
  logic        rst, transfer_start, mstr, cpol, cpha, dord, talk;
  logic [4:0]  data_len;
  logic [7:0]  spi_br;
  logic [31:0] tx_data, rx_data;
  logic        transfer_start_ack, transfer_complete, sck, mosi, ss_n, miso;
  logic        miso_reg, loop_en;

  always #5 clk = ~clk;

  assign miso = loop_en ? mosi : miso_reg;

  spi_shift_engine dut (
    .clk                (clk),
    .rst                (rst),
    .transfer_start     (transfer_start),
    .transfer_start_ack (transfer_start_ack),
    .transfer_complete  (transfer_complete),
    .mstr               (mstr),
    .cpol               (cpol),
    .cpha               (cpha),
    .dord               (dord),
    .talk               (talk),
    .data_len           (data_len),
    .spi_br             (spi_br),
    .tx_data            (tx_data),
    .rx_data            (rx_data),
    .sck                (sck),
    .mosi               (mosi),
    .miso               (miso),
    .ss_n               (ss_n)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: bit i of the frame in transmission order.
  function automatic logic [31:0] model_mosi(input logic [4:0] len, input logic d,
                                             input logic t, input logic [31:0] tx);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i <= int'(len); i++) begin
      w[i] = t ? (d ? tx[i] : tx[int'(len) - i]) : 1'b1;
    end
    return w;
  endfunction

  // Reference model: i-th received bit lands at bit i (LSB first) or bit len-i (MSB first).
  function automatic logic [31:0] model_rx(input logic [4:0] len, input logic d,
                                           input logic [31:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i <= int'(len); i++) begin
      r[d ? i : int'(len) - i] = m[i];
    end
    return r;
  endfunction

  // Runs one frame acting as the slave; m holds miso bits in reception order.
  task automatic run_frame(input string tag, input logic c_cpol, input logic c_cpha,
                           input logic c_dord, input logic c_talk, input logic c_loop,
                           input logic [4:0] c_len, input logic [7:0] c_br,
                           input logic [31:0] c_tx, input logic [31:0] c_m,
                           input logic [31:0] exp_rx, input logic [31:0] exp_mosi,
                           input int exp_edges, input bit hold, input bit perturb);
    int acks, edges, samp, last_edge, budget;
    logic [31:0] obs_mosi, pre_rx, end_rx;
    logic prev_sck, prev_ss, done, end_cmp;
    logic space_ok, trail_ok, talk_ok, clr_ok, ss_ok, rx_hold_ok;
    cpol = c_cpol; cpha = c_cpha; dord = c_dord; talk = c_talk; loop_en = c_loop;
    data_len = c_len; spi_br = c_br; tx_data = c_tx; mstr = 1'b1;
    miso_reg = c_m[0]; transfer_start = 1'b0;
    repeat (2) @(negedge clk);
    acks = 0; edges = 0; samp = 0; last_edge = 0; obs_mosi = '0;
    done = 1'b0; space_ok = 1'b1; trail_ok = 1'b1; talk_ok = 1'b1;
    clr_ok = 1'b1; ss_ok = 1'b1; rx_hold_ok = 1'b1;
    end_rx = '0; end_cmp = 1'b0;
    pre_rx = rx_data; prev_sck = sck; prev_ss = ss_n;
    budget = 4 * (int'(c_len) + 3) * (int'(c_br) + 1) + 40;
    transfer_start = 1'b1;
    for (int cyc = 1; cyc <= budget && !done; cyc++) begin
      @(negedge clk);
      if (transfer_start_ack) begin
        acks++;
        if (transfer_complete !== 1'b0) clr_ok = 1'b0;
        if (!hold) transfer_start = 1'b0;
      end
      if (perturb && cyc == 2 * (int'(c_br) + 1) + 3) begin
        tx_data = ~c_tx; spi_br = c_br + 8'd5; data_len = c_len ^ 5'd7;
        dord = ~c_dord; talk = ~c_talk; cpha = ~c_cpha; transfer_start = 1'b1;
      end
      if (perturb && cyc == 2 * (int'(c_br) + 1) + 6) transfer_start = 1'b0;
      if (sck !== prev_sck) begin
        edges++;
        if (edges > 1 && cyc - last_edge != int'(c_br) + 1) space_ok = 1'b0;
        if (ss_n !== 1'b0) ss_ok = 1'b0;
        last_edge = cyc;
        // Slave samples on leading edges for cpha=0, trailing for cpha=1.
        if (((edges % 2) == 1) != c_cpha) begin
          if (samp < 32) obs_mosi[samp] = mosi;
          samp++;
          if (samp < 32) miso_reg = c_m[samp];
        end
      end
      if (!c_talk && ss_n === 1'b0 && mosi !== 1'b1) talk_ok = 1'b0;
      if (prev_ss === 1'b0 && ss_n === 1'b1) begin
        done = 1'b1;
        if (cyc - last_edge != int'(c_br) + 1) trail_ok = 1'b0;
        end_rx = rx_data; end_cmp = transfer_complete;
      end else if (rx_data !== pre_rx) begin
        rx_hold_ok = 1'b0;
      end
      prev_sck = sck; prev_ss = ss_n;
    end
    if (hold) begin
      repeat (30) begin
        @(negedge clk);
        if (transfer_start_ack) acks++;
      end
    end
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".acks"}, acks, 1);
    check({tag, ".complete"}, end_cmp, 1'b1);
    check({tag, ".rx_data"}, end_rx, exp_rx);
    check({tag, ".edges"}, edges, exp_edges);
    check({tag, ".mosi_seq"}, obs_mosi, exp_mosi);
    check({tag, ".edge_spacing"}, space_ok, 1'b1);
    check({tag, ".trail_len"}, trail_ok, 1'b1);
    check({tag, ".ss_low"}, ss_ok, 1'b1);
    check({tag, ".cmp_clr_on_ack"}, clr_ok, 1'b1);
    check({tag, ".rx_stable"}, rx_hold_ok, 1'b1);
    if (!c_talk) check({tag, ".mosi_quiet"}, talk_ok, 1'b1);
    cpha = c_cpha; dord = c_dord; talk = c_talk; tx_data = c_tx;
    spi_br = c_br; data_len = c_len;
    @(negedge clk);
    check({tag, ".sck_idle"}, sck, c_cpol);
    check({tag, ".mosi_idle"}, mosi, 1'b1);
  endtask

  typedef struct {
    logic        cpol, cpha, dord, talk, loopb, perturb;
    logic [4:0]  len;
    logic [7:0]  br;
    logic [31:0] tx, m, exp_rx, exp_mosi;
    int          exp_edges;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // cpol cpha dord talk loop pert  len   br     tx            miso          rx            mosi seq      edges
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7,  8'd1, 32'h000000A5, 32'h0,        32'h000000A5, 32'h000000A5, 16};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 8'd0, 32'h80000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 64};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3,  8'd2, 32'h00000009, 32'h00000006, 32'h00000006, 32'h00000009, 8};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4,  8'd0, 32'h00000000, 32'h00000016, 32'h00000016, 32'h0000001F, 10};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  8'd3, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 32'h00000000, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd15, 8'd1, 32'h1234C0DE, 32'h0000F00F, 32'h0000F00F, 32'h00007B03, 32};

    rst = 1'b1; transfer_start = 1'b0; mstr = 1'b1; cpol = 1'b1; cpha = 1'b0;
    dord = 1'b0; talk = 1'b1; data_len = 5'd0; spi_br = 8'd0; tx_data = '0;
    miso_reg = 1'b0; loop_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.sck", sck, 1'b0);
    check("reset.mosi", mosi, 1'b1);
    check("reset.ss_n", ss_n, 1'b1);
    check("reset.ack", transfer_start_ack, 1'b0);
    check("reset.complete", transfer_complete, 1'b0);
    check("reset.rx_data", rx_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_frame($sformatf("vec%0d", v), vecs[v].cpol, vecs[v].cpha, vecs[v].dord,
                vecs[v].talk, vecs[v].loopb, vecs[v].len, vecs[v].br, vecs[v].tx,
                vecs[v].m, vecs[v].exp_rx, vecs[v].exp_mosi, vecs[v].exp_edges,
                1'b0, vecs[v].perturb);
    end

    // Abort at edge 5 of a 16-bit frame; cpol=1 makes the sck reset value distinguishable.
    begin
      logic prev, hit;
      int edges;
      cpol = 1'b1; cpha = 1'b0; dord = 1'b0; talk = 1'b1; data_len = 5'd15;
      spi_br = 8'd1; tx_data = 32'hDEADBEEF; mstr = 1'b1; loop_en = 1'b0;
      miso_reg = 1'b1; transfer_start = 1'b0;
      repeat (2) @(negedge clk);
      prev = sck; edges = 0; hit = 1'b0;
      transfer_start = 1'b1;
      for (int c = 0; c < 400 && !hit; c++) begin
        @(negedge clk);
        if (transfer_start_ack) transfer_start = 1'b0;
        if (sck !== prev) edges++;
        prev = sck;
        if (edges == 5) hit = 1'b1;
      end
      check("abort.edge5_reached", hit, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("abort.sck", sck, 1'b0);
      check("abort.ss_n", ss_n, 1'b1);
      check("abort.complete", transfer_complete, 1'b0);
      check("abort.rx_data", rx_data, 32'h0);
      check("abort.state", dut.r_state, SPI_package::IDLE);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("abort.no_late_complete", transfer_complete, 1'b0);
      check("abort.ss_stays_high", ss_n, 1'b1);
    end

    // Request held through and past the frame, then dropped and raised again.
    run_frame("held", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 32'h1, 32'h0,
              32'h0, 32'h1, 2, 1'b1, 1'b0);
    run_frame("rearm", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, 32'h1, 32'h1,
              32'h1, 32'h1, 2, 1'b0, 1'b0);

    for (int r = 0; r < 14; r++) begin
      logic c_cpol, c_cpha, c_dord, c_talk;
      logic [4:0] c_len;
      logic [7:0] c_br;
      logic [31:0] c_tx, c_m;
      c_cpol = 1'($urandom); c_cpha = 1'($urandom); c_dord = 1'($urandom);
      c_talk = ($urandom_range(0, 3) != 0);
      c_len = 5'($urandom_range(0, 31)); c_br = 8'($urandom_range(0, 3));
      c_tx = $urandom; c_m = $urandom;
      run_frame($sformatf("rand%0d", r), c_cpol, c_cpha, c_dord, c_talk, 1'b0,
                c_len, c_br, c_tx, c_m, model_rx(c_len, c_dord, c_m),
                model_mosi(c_len, c_dord, c_talk, c_tx), 2 * (int'(c_len) + 1),
                1'b0, 1'b0);
    end

    // Slave mode: a standing request must never be accepted.
    begin
      int acks;
      logic ss_hi;
      acks = 0; ss_hi = 1'b1;
      mstr = 1'b0; transfer_start = 1'b1;
      repeat (100) begin
        @(negedge clk);
        if (transfer_start_ack) acks++;
        if (ss_n !== 1'b1) ss_hi = 1'b0;
      end
      check("slave.acks", acks, 0);
      check("slave.ss_n_high", ss_hi, 1'b1);
      transfer_start = 1'b0; mstr = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

Interface
REQ-001 The block SHALL be single-clock with synchronous, active-high reset; ports clk and rst.
REQ-002 Parameter SPI_MAX_LEN, default 32, SHALL set the maximum frame length in bits.
REQ-003 clk  in  1  system clock; every register SHALL be clocked on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 transfer_start  in  1  level request from the controller to send one frame.
REQ-006 transfer_start_ack  out  1  one-cycle pulse when a request is accepted.
REQ-007 transfer_complete  out  1  level; set at frame end, cleared on the next accept.
REQ-008 mstr, cpol, cpha, dord, talk  in  1 each  mode inputs; dord=0 sends MSB first, talk=0 sends no data.
REQ-009 data_len  in  5  frame length minus one (0..31 gives 1..32 bits).
REQ-010 spi_br  in  8  baud divisor; SCK half-period is (spi_br+1) clk cycles.
REQ-011 tx_data  in  32  frame to transmit; rx_data  out  32  received frame, right-justified.
REQ-012 sck  out  1; mosi  out  1; miso  in  1; ss_n  out  1  (SPI pins, all registered outputs except miso).

Function
REQ-013 FSM states SHALL be IDLE, LEAD, SHIFT and TRAIL, encoded as an enum.
REQ-014 IDLE -> LEAD SHALL occur when transfer_start=1, mstr=1 and armed=1.
- On that cycle: pulse ack, clear transfer_complete and armed, drive ss_n=0.
- Latch tx_data, data_len, cpol, cpha, dord, talk and spi_br; input changes mid-frame SHALL have no effect.
REQ-015 armed SHALL be set whenever transfer_start=0 is sampled, so that one held request yields exactly one frame.
REQ-016 With mstr=0 the block SHALL stay in IDLE and never acknowledge.
REQ-017 LEAD SHALL last one half-period, then go to SHIFT.
REQ-018 SHIFT SHALL produce 2*(data_len+1) SCK toggles, one half-period apart.
- Edge 1 leaves the cpol level; odd edges are leading, even edges are trailing.
REQ-019 cpha=0 timing:
- First bit is on mosi from the LEAD entry.
- miso is sampled on leading edges.
- mosi advances on trailing edges, except the final one.
REQ-020 cpha=1 timing:
- mosi advances on leading edges; the first bit is driven at edge 1.
- miso is sampled on trailing edges.
REQ-021 With talk=0, mosi SHALL be held at 1 for the whole frame; reception SHALL be unaffected.
REQ-022 After the last edge, TRAIL SHALL last one half-period. On exit:
- set ss_n=1 and transfer_complete=1;
- load rx_data with the received bits in [data_len:0] and zeros above;
- return to IDLE.
REQ-023 Received bit order SHALL follow dord; the first bit received lands in bit data_len (dord=0) or bit 0 (dord=1).
REQ-024 In IDLE, sck SHALL follow cpol one cycle late and mosi SHALL be 1.
REQ-025 The half-period counter SHALL be 8 bits and reload on every edge; spi_br=255 gives 256-cycle half-periods without overflow.
REQ-026 The edge counter SHALL be 6 bits; data_len=31 gives 64 edges without wrap.
REQ-027 A transfer_start edge arriving while not in IDLE SHALL be ignored; no ack SHALL be issued.
REQ-028 rx_data SHALL change only at the TRAIL exit.

Reset
REQ-029 rst SHALL return the block to IDLE from any state; a frame aborted mid-way SHALL NOT set transfer_complete.
REQ-030 Reset values: sck=0, mosi=1, ss_n=1, transfer_start_ack=0, transfer_complete=0, rx_data=0, armed=1, all counters 0.

Structure
REQ-031 The FSM state enum and the constant SPI_MAX_LEN SHALL be added to SPI_package.
REQ-032 Half-period generation SHALL be a sub-module, spi_baud_gen, with this interface:
- inputs: clk, rst, enable, spi_br;
- output: half_tick, a one-cycle pulse every spi_br+1 cycles while enable=1;
- the count SHALL restart from zero when enable rises.

Verification
REQ-033 Mode 0 frame: cpol=0, cpha=0, dord=0, data_len=7, spi_br=1, tx=0xA5, miso looped to mosi.
- Expect one ack, 16 sck edges at 2-cycle spacing, mosi sequence 1,0,1,0,0,1,0,1, rx_data=0x000000A5, complete=1.
REQ-034 Mode 3, LSB first, full width: cpol=1, cpha=1, dord=1, data_len=31, spi_br=0, tx=0x80000001, miso tied 1.
- Expect 64 edges, sck idle high, first mosi bit 1, rx_data=0xFFFFFFFF.
REQ-035 Held request: transfer_start held high through the complete frame (data_len=0).
- Expect exactly one ack. Drop then re-raise start: expect a second frame, with complete cleared on its ack.
REQ-036 Abort: assert rst at edge 5 of a data_len=15 frame.
- Expect next cycle sck=0, ss_n=1, complete=0, rx_data=0, state IDLE.
REQ-037 Slave and mid-frame changes:
- mstr=0 with start=1 for 100 cycles: expect no ack and ss_n=1.
- Change tx_data and spi_br mid-frame: expect waveform unchanged from the latched values.
